// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared state encoding and limits for the run-time clock divider
package clk_div_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] STOP = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_RUN  = RUN,
        S_STOP = STOP
    } state_t;

    // Smallest ratio that still yields a non-zero high and low phase.
    localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_core.sv
// rtl/clk_div_core.sv - divide-by-N counter and registered clk_out/edge pulses
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [CNT_W-1:0] div,
    output logic             clk_out,
    output logic             rise_pls,
    output logic             fall_pls,
    output logic             boundary
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] last;

    // div is always >= 2 here, so half >= 1 and last >= 1.
    assign half     = div >> 1;
    assign last     = div - CNT_W'(1);
    assign boundary = run && (cnt == last);

    // Outputs are derived from the counter value of the previous cycle, so the
    // first high cycle appears one edge after run rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            clk_out  <= 1'b0;
            rise_pls <= 1'b0;
            fall_pls <= 1'b0;
        end else if (!run) begin
            cnt      <= '0;
            clk_out  <= 1'b0;
            rise_pls <= 1'b0;
            fall_pls <= 1'b0;
        end else begin
            cnt      <= boundary ? '0 : cnt + CNT_W'(1);
            clk_out  <= (cnt < half);
            rise_pls <= (cnt == '0);
            fall_pls <= (cnt == half);
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - start/stop sequencing and glitch-free ratio updates for the divider
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             rise_pls,
    output logic             fall_pls,
    output logic             busy
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] div_reg;
    logic [CNT_W-1:0] pend_reg;
    logic             pend;
    logic             boundary;
    logic             run;
    logic             xfer;
    logic             div_ok;

    assign run       = (state_q != S_IDLE);
    assign busy      = run;
    assign cfg_ready = (state_q == S_IDLE) || !pend;
    assign xfer      = cfg_valid && cfg_ready;
    assign div_ok    = (cfg_div >= CNT_W'(MIN_DIV));

    clk_div_core #(
        .CNT_W(CNT_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .div      (div_reg),
        .clk_out  (clk_out),
        .rise_pls (rise_pls),
        .fall_pls (fall_pls),
        .boundary (boundary)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: stopping always lets the running period reach its boundary;
    // if en drops on the boundary cycle itself that period is already complete.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!en) begin
                    state_d = boundary ? S_IDLE : S_STOP;
                end
            end
            S_STOP: begin
                if (boundary) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Ratio bookkeeping: direct load while idle, otherwise park in pend_reg
    // until the next period boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_reg  <= CNT_W'(DEF_DIV);
            pend_reg <= '0;
            pend     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= xfer && !div_ok;
            if (state_q == S_IDLE) begin
                if (xfer && div_ok) begin
                    div_reg <= cfg_div;
                end
            end else begin
                if (boundary && pend) begin
                    div_reg <= pend_reg;
                    pend    <= 1'b0;
                end
                // xfer here implies pend was clear, so this never collides
                // with the boundary update above.
                if (xfer && div_ok) begin
                    pend_reg <= cfg_div;
                    pend     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - self-checking bench for clk_div_ctrl against a period-queue model
module tb_clk_div_ctrl;

    localparam int CNT_W   = 8;
    localparam int DEF_DIV = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [CNT_W-1:0] cfg_div = '0;
    logic             cfg_ready;
    logic             cfg_err;
    logic             clk_out;
    logic             rise_pls;
    logic             fall_pls;
    logic             busy;

    logic [5:0] dut_vec;
    logic [5:0] exp_vec;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: a queue holds the clk_out values still to be emitted
    // in the current period, built from N as H ones followed by N-H zeros.
    bit m_active;
    bit m_stop;
    bit m_pend_v;
    int m_pend;
    int m_div;
    int m_pos;
    int m_h;
    bit q[$];
    bit e_clk, e_rise, e_fall, e_err;

    assign dut_vec = {clk_out, rise_pls, fall_pls, busy, cfg_ready, cfg_err};

    clk_div_ctrl #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .rise_pls  (rise_pls),
        .fall_pls  (fall_pls),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_active = 0;
        m_stop   = 0;
        m_pend_v = 0;
        m_pend   = 0;
        m_div    = DEF_DIV;
        m_pos    = 0;
        m_h      = 0;
        q.delete();
        e_clk = 0; e_rise = 0; e_fall = 0; e_err = 0;
        exp_vec = 6'b000010;
    endtask

    // Drive one cycle of inputs, advance one edge, update the model, then settle.
    task automatic cycle(input bit i_en, input bit i_v, input int i_div);
        bit rdy, xf, ok;
        en        = i_en;
        cfg_valid = i_v;
        cfg_div   = i_div[CNT_W-1:0];
        rdy = !m_active || !m_pend_v;
        xf  = i_v && rdy;
        ok  = (i_div >= 2);
        @(posedge clk);
        e_err = xf && !ok;
        if (!m_active) begin
            e_clk = 0; e_rise = 0; e_fall = 0;
            if (xf && ok) m_div = i_div;
            if (i_en) begin
                m_active = 1;
                m_stop   = 0;
            end
        end else begin
            if (q.size() == 0) begin
                m_h = m_div / 2;
                for (int i = 0; i < m_div; i++) q.push_back(i < m_h);
                m_pos = 0;
            end
            e_clk  = q.pop_front();
            e_rise = (m_pos == 0);
            e_fall = (m_pos == m_h);
            m_pos++;
            if (!i_en) m_stop = 1;
            if (q.size() == 0) begin
                if (m_pend_v) begin
                    m_div    = m_pend;
                    m_pend_v = 0;
                end
                if (m_stop) m_active = 0;
            end
            if (xf && ok) begin
                m_pend   = i_div;
                m_pend_v = 1;
            end
        end
        exp_vec = {e_clk, e_rise, e_fall, m_active, (!m_active || !m_pend_v), e_err};
        #1;
    endtask

    task automatic go_idle();
        int guard = 0;
        cycle(0, 0, 0);
        while (m_active && guard < 600) begin
            cycle(0, 0, 0);
            guard++;
        end
        n_cmp++;
        if (busy !== 1'b0 || m_active) begin
            n_bad++;
            $display("FAIL go_idle: busy=%b model_active=%b required busy=0", busy, m_active);
        end
    endtask

    task automatic test_reset();
        rst = 0;
        en = 0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (dut_vec !== 6'b000010) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b required %b", dut_vec, 6'b000010);
        end
        rst = 1;
        model_reset();
        cycle(0, 0, 0);
        n_cmp++;
        if (dut_vec !== exp_vec || dut_vec !== 6'b000010) begin
            n_bad++;
            $display("FAIL reset_idle: got %b required %b", dut_vec, exp_vec);
        end
    endtask

    task automatic test_default_run();
        logic [9:0] pat_c = 10'b0110011001;
        logic [9:0] pat_r = 10'b0100010001;
        logic [9:0] pat_f = 10'b0001000100;
        for (int k = 0; k < 10; k++) begin
            cycle(1, 0, 0);
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL default_model k=%0d: got %b required %b", k, dut_vec, exp_vec);
            end
            n_cmp++;
            if ({clk_out, rise_pls, fall_pls} !== {pat_c[9-k], pat_r[9-k], pat_f[9-k]}) begin
                n_bad++;
                $display("FAIL default_shape k=%0d: got %b required %b", k,
                         {clk_out, rise_pls, fall_pls}, {pat_c[9-k], pat_r[9-k], pat_f[9-k]});
            end
        end
        go_idle();
    endtask

    task automatic test_run_change();
        logic [12:0] pat = 13'b0111000111000;
        for (int k = 0; k < 3; k++) cycle(1, 0, 0);
        cycle(1, 1, 6);
        n_cmp++;
        if (cfg_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL run_change_ready_low: got %b required 0", cfg_ready);
        end
        for (int k = 0; k < 13; k++) begin
            cycle(1, 0, 0);
            if (k == 0) begin
                n_cmp++;
                if (cfg_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL run_change_ready_back: got %b required 1", cfg_ready);
                end
            end
            n_cmp++;
            if (clk_out !== pat[12-k] || dut_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL run_change k=%0d: clk_out %b required %b, vec %b required %b",
                         k, clk_out, pat[12-k], dut_vec, exp_vec);
            end
        end
        go_idle();
    endtask

    task automatic test_idle_cfg();
        int ratios[3] = '{5, 2, 255};
        for (int r = 0; r < 3; r++) begin
            int n, hi, lo, nr, nf;
            n = ratios[r];
            hi = 0; lo = 0; nr = 0; nf = 0;
            cycle(0, 1, n);
            n_cmp++;
            if (cfg_err !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_cfg_accept n=%0d: err=%b ready=%b busy=%b required 0/1/0",
                         n, cfg_err, cfg_ready, busy);
            end
            cycle(1, 0, 0);
            for (int k = 0; k < n; k++) begin
                cycle(1, 0, 0);
                if (clk_out) hi++; else lo++;
                if (rise_pls) nr++;
                if (fall_pls) nf++;
                n_cmp++;
                if (dut_vec !== exp_vec) begin
                    n_bad++;
                    $display("FAIL idle_cfg_model n=%0d k=%0d: got %b required %b", n, k, dut_vec, exp_vec);
                end
            end
            n_cmp++;
            if (hi != n / 2 || lo != n - n / 2 || nr != 1 || nf != 1) begin
                n_bad++;
                $display("FAIL idle_cfg_shape n=%0d: hi=%0d lo=%0d rise=%0d fall=%0d required %0d/%0d/1/1",
                         n, hi, lo, nr, nf, n / 2, n - n / 2);
            end
            go_idle();
        end
    endtask

    task automatic test_cfg_err();
        cycle(0, 1, 3);
        cycle(0, 1, 1);
        n_cmp++;
        if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL err_idle_1: err=%b ready=%b required 1/1", cfg_err, cfg_ready);
        end
        cycle(0, 1, 0);
        n_cmp++;
        if (cfg_err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_idle_0: err=%b required 1", cfg_err);
        end
        cycle(0, 0, 0);
        n_cmp++;
        if (cfg_err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear: err=%b required 0", cfg_err);
        end
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        n_cmp++;
        if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL err_run: err=%b ready=%b required 1/1", cfg_err, cfg_ready);
        end
        for (int k = 0; k < 8; k++) begin
            cycle(1, 0, 0);
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL err_run_model k=%0d: got %b required %b", k, dut_vec, exp_vec);
            end
        end
        go_idle();
    endtask

    task automatic test_stop_restart();
        logic [8:0] pat_en   = 9'b111001111;
        logic [8:0] pat_busy = 9'b111111011;
        logic [8:0] pat_clk  = 9'b011100001;
        cycle(0, 1, 6);
        for (int k = 0; k < 9; k++) begin
            cycle(pat_en[8-k], 0, 0);
            n_cmp++;
            if (busy !== pat_busy[8-k] || clk_out !== pat_clk[8-k] || dut_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL stop_restart k=%0d: busy=%b clk_out=%b vec=%b required %b/%b/%b",
                         k, busy, clk_out, dut_vec, pat_busy[8-k], pat_clk[8-k], exp_vec);
            end
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        logic [9:0] pat_c = 10'b0110011001;
        cycle(0, 1, 6);
        for (int k = 0; k < 3; k++) cycle(1, 0, 0);
        cycle(1, 1, 9);
        #2;
        rst = 0;
        #1;
        n_cmp++;
        if (dut_vec !== 6'b000010) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got %b required %b", dut_vec, 6'b000010);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        for (int k = 0; k < 10; k++) begin
            cycle(1, 0, 0);
            n_cmp++;
            if (clk_out !== pat_c[9-k] || dut_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL reset_mid_restart k=%0d: clk_out=%b vec=%b required %b/%b",
                         k, clk_out, dut_vec, pat_c[9-k], exp_vec);
            end
        end
        go_idle();
    endtask

    task automatic test_random();
        bit r_en = 0;
        for (int k = 0; k < 3000; k++) begin
            bit v;
            int d;
            if ($urandom_range(0, 19) == 0) r_en = !r_en;
            v = ($urandom_range(0, 4) == 0);
            d = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9));
            cycle(r_en, v, d);
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL random k=%0d: got %b required %b", k, dut_vec, exp_vec);
            end
            if ($urandom_range(0, 499) == 0) begin
                #2;
                rst = 0;
                #1;
                model_reset();
                n_cmp++;
                if (dut_vec !== 6'b000010) begin
                    n_bad++;
                    $display("FAIL random_reset k=%0d: got %b required %b", k, dut_vec, 6'b000010);
                end
                @(posedge clk);
                #1;
                rst = 1;
            end
        end
        go_idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_default_run();
        test_run_change();
        test_idle_cfg();
        test_cfg_err();
        test_stop_restart();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
